// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU-16 operand-fetch stage.
//   state_t   : sequencing FSM states (exported on dbg_state)
//   opmode_t  : operand addressing-mode classes from the 6-bit field decoder
//   spdelta_t : stack-pointer side effect of an operand
//   AMOD_*    : destination-kind codes driven on amod
//   EA_*      : ea values used with AMOD_SPC to pick SP/PC/O
package dcpu16_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_OPA,
      ST_NWA,
      ST_LDA,
      ST_OPB,
      ST_NWB,
      ST_LDB,
      ST_EXE
   } state_t;

   typedef enum logic [3:0] {
      OP_REG,   // 0x00-0x07  register
      OP_IND,   // 0x08-0x0f  [register]
      OP_IDX,   // 0x10-0x17  [next word + register]
      OP_POP,   // 0x18       [SP++]
      OP_PEEK,  // 0x19       [SP]
      OP_PUSH,  // 0x1a       [--SP]
      OP_SP,    // 0x1b       SP
      OP_PC,    // 0x1c       PC
      OP_O,     // 0x1d       O
      OP_NWI,   // 0x1e       [next word]
      OP_NWL,   // 0x1f       next word literal
      OP_LIT    // 0x20-0x3f  short literal
   } opmode_t;

   typedef enum logic [1:0] {
      SPD_NONE,
      SPD_INC,
      SPD_DEC
   } spdelta_t;

   localparam logic [1:0] AMOD_REG = 2'd0;
   localparam logic [1:0] AMOD_MEM = 2'd1;
   localparam logic [1:0] AMOD_LIT = 2'd2;
   localparam logic [1:0] AMOD_SPC = 2'd3;

   localparam logic [15:0] EA_SP = 16'd0;
   localparam logic [15:0] EA_PC = 16'd1;
   localparam logic [15:0] EA_O  = 16'd2;

endpackage

// File: rtl/dcpu16_opdec.sv
// Combinational decoder for one 6-bit DCPU-16 operand field.
//   fld      : operand field (a or b)
//   mode     : addressing-mode class
//   needs_nw : operand consumes a next word at PC
//   needs_ld : operand value comes from a memory read at a pointer
//   sp_delta : SP side effect applied when the field is decoded
module dcpu16_opdec
   import dcpu16_pkg::*;
(
   input  logic [5:0] fld,
   output opmode_t    mode,
   output logic       needs_nw,
   output logic       needs_ld,
   output spdelta_t   sp_delta
);

   always_comb begin
      mode     = OP_LIT;
      needs_nw = 1'b0;
      needs_ld = 1'b0;
      sp_delta = SPD_NONE;
      if (!fld[5]) begin
         unique case (fld[4:3])
            2'b00: mode = OP_REG;
            2'b01: begin
               mode     = OP_IND;
               needs_ld = 1'b1;
            end
            2'b10: begin
               mode     = OP_IDX;
               needs_nw = 1'b1;
               needs_ld = 1'b1;
            end
            default: begin
               unique case (fld[2:0])
                  3'd0: begin
                     mode     = OP_POP;
                     needs_ld = 1'b1;
                     sp_delta = SPD_INC;
                  end
                  3'd1: begin
                     mode     = OP_PEEK;
                     needs_ld = 1'b1;
                  end
                  3'd2: begin
                     mode     = OP_PUSH;
                     needs_ld = 1'b1;
                     sp_delta = SPD_DEC;
                  end
                  3'd3: mode = OP_SP;
                  3'd4: mode = OP_PC;
                  3'd5: mode = OP_O;
                  3'd6: begin
                     mode     = OP_NWI;
                     needs_nw = 1'b1;
                     needs_ld = 1'b1;
                  end
                  default: begin
                     mode     = OP_NWL;
                     needs_nw = 1'b1;
                  end
               endcase
            end
         endcase
      end
   end

endmodule

// File: rtl/dcpu16_opf.sv
// DCPU-16 operand-fetch and sequencing stage, upstream of the ALU.
// Fetches the instruction at PC, resolves operand a then operand b (next
// words, memory indirection, stack push/pop), then strobes the ALU.
//   clk, rst            : clock, synchronous active-high reset
//   ab_adr/ab_stb       : bus read request, held stable until ab_ack
//   ab_ack/ab_dti       : bus acknowledge and read data (same cycle)
//   rra/rrd             : register-file read index / combinational data
//   regO_i              : current O register
//   skp                 : skip the instruction currently in EXE
//   pcw/pcd, spw/spd    : PC / SP writes from writeback (win over internal updates)
//   opc, regA, regB     : opcode and operand values to the ALU
//   ena                 : one-cycle execute strobe
//   ea, amod            : destination of operand a and its kind
//   nbi                 : one-cycle pulse, non-basic instruction ignored
//   pc, sp              : current PC and SP
//   dbg_state           : current FSM state
//
// Bus handshake: a read is outstanding in every cycle ab_stb is high;
// ab_adr does not change while ab_stb is high and ab_ack is low, and the
// transfer completes in the cycle where ab_stb and ab_ack are both high.
module dcpu16_opf
   import dcpu16_pkg::*;
#(
   parameter logic [15:0] RST_PC = 16'h0000,
   parameter logic [15:0] RST_SP = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] ab_adr,
   output logic        ab_stb,
   input  logic        ab_ack,
   input  logic [15:0] ab_dti,
   output logic [2:0]  rra,
   input  logic [15:0] rrd,
   input  logic [15:0] regO_i,
   input  logic        skp,
   input  logic        pcw,
   input  logic [15:0] pcd,
   input  logic        spw,
   input  logic [15:0] spd,
   output logic [3:0]  opc,
   output logic [15:0] regA,
   output logic [15:0] regB,
   output logic        ena,
   output logic [15:0] ea,
   output logic [1:0]  amod,
   output logic        nbi,
   output logic [15:0] pc,
   output logic [15:0] sp,
   output state_t      dbg_state
);

   state_t      state;
   logic [15:0] ir;
   logic [15:0] ptr;

   logic        is_b;
   logic [5:0]  fld;
   opmode_t     mode;
   logic        needs_nw;
   logic        needs_ld;
   spdelta_t    sp_delta;
   logic [15:0] imm_val;
   logic [15:0] nw_ptr;

   // All per-operand states of b share the single decoder with a.
   assign is_b = (state == ST_OPB) || (state == ST_NWB) || (state == ST_LDB);
   assign fld  = is_b ? ir[15:10] : ir[9:4];

   dcpu16_opdec u_opdec (
      .fld      (fld),
      .mode     (mode),
      .needs_nw (needs_nw),
      .needs_ld (needs_ld),
      .sp_delta (sp_delta)
   );

   // Operand values that resolve in the decode cycle itself.
   always_comb begin
      imm_val = 16'h0000;
      unique case (mode)
         OP_REG:  imm_val = rrd;
         OP_SP:   imm_val = sp;
         OP_PC:   imm_val = pc;
         OP_O:    imm_val = regO_i;
         OP_LIT:  imm_val = {11'b0, fld[4:0]};
         default: imm_val = 16'h0000;
      endcase
   end

   // [nw+reg] adds the register captured at decode; [nw] uses nw alone.
   assign nw_ptr = (mode == OP_IDX) ? (ab_dti + ptr) : ab_dti;

   assign ab_stb = !rst && ((state == ST_FETCH) || (state == ST_NWA) || (state == ST_NWB) ||
                            (state == ST_LDA) || (state == ST_LDB));
   assign ab_adr = ((state == ST_LDA) || (state == ST_LDB)) ? ptr : pc;
   assign rra    = (!rst && ((state == ST_OPA) || (state == ST_OPB))) ? fld[2:0] : 3'd0;

   // skp is only meaningful in the EXE cycle, so the strobes are decoded
   // from the registered state rather than registered themselves.
   assign ena = !rst && (state == ST_EXE) && (opc != 4'd0) && !skp;
   assign nbi = !rst && (state == ST_EXE) && (opc == 4'd0);

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
         pc    <= RST_PC;
         sp    <= RST_SP;
         ir    <= 16'h0000;
         ptr   <= 16'h0000;
         opc   <= 4'd0;
         regA  <= 16'h0000;
         regB  <= 16'h0000;
         ea    <= 16'h0000;
         amod  <= AMOD_REG;
      end else begin
         unique case (state)
            ST_FETCH: begin
               if (ab_ack) begin
                  ir    <= ab_dti;
                  opc   <= ab_dti[3:0];
                  pc    <= pc + 16'd1;
                  state <= ST_OPA;
               end
            end

            ST_OPA, ST_OPB: begin
               unique case (mode)
                  OP_IND, OP_IDX:  ptr <= rrd;
                  OP_POP, OP_PEEK: ptr <= sp;
                  OP_PUSH:         ptr <= sp - 16'd1;
                  default:         ;
               endcase

               unique case (sp_delta)
                  SPD_INC: sp <= sp + 16'd1;
                  SPD_DEC: sp <= sp - 16'd1;
                  default: ;
               endcase

               // Destination of a; [nw+reg] and [nw] finish ea in NWA.
               if (!is_b) begin
                  unique case (mode)
                     OP_REG: begin
                        amod <= AMOD_REG;
                        ea   <= {13'b0, fld[2:0]};
                     end
                     OP_IND: begin
                        amod <= AMOD_MEM;
                        ea   <= rrd;
                     end
                     OP_POP, OP_PEEK: begin
                        amod <= AMOD_MEM;
                        ea   <= sp;
                     end
                     OP_PUSH: begin
                        amod <= AMOD_MEM;
                        ea   <= sp - 16'd1;
                     end
                     OP_IDX, OP_NWI: amod <= AMOD_MEM;
                     OP_SP: begin
                        amod <= AMOD_SPC;
                        ea   <= EA_SP;
                     end
                     OP_PC: begin
                        amod <= AMOD_SPC;
                        ea   <= EA_PC;
                     end
                     OP_O: begin
                        amod <= AMOD_SPC;
                        ea   <= EA_O;
                     end
                     default: begin
                        amod <= AMOD_LIT;
                        ea   <= 16'h0000;
                     end
                  endcase
               end

               if (needs_nw) begin
                  state <= is_b ? ST_NWB : ST_NWA;
               end else if (needs_ld) begin
                  state <= is_b ? ST_LDB : ST_LDA;
               end else begin
                  if (is_b) regB <= imm_val;
                  else      regA <= imm_val;
                  state <= is_b ? ST_EXE : ST_OPB;
               end
            end

            ST_NWA, ST_NWB: begin
               if (ab_ack) begin
                  pc <= pc + 16'd1;
                  if (needs_ld) begin
                     ptr <= nw_ptr;
                     if (!is_b) ea <= nw_ptr;
                     state <= is_b ? ST_LDB : ST_LDA;
                  end else begin
                     if (is_b) regB <= ab_dti;
                     else      regA <= ab_dti;
                     state <= is_b ? ST_EXE : ST_OPB;
                  end
               end
            end

            ST_LDA: begin
               if (ab_ack) begin
                  regA  <= ab_dti;
                  state <= ST_OPB;
               end
            end

            ST_LDB: begin
               if (ab_ack) begin
                  regB  <= ab_dti;
                  state <= ST_EXE;
               end
            end

            default: state <= ST_FETCH;  // ST_EXE
         endcase

         // Writeback updates override any same-cycle increment/decrement.
         if (pcw) pc <= pcd;
         if (spw) sp <= spd;
      end
   end

endmodule

// File: tb/tb_dcpu16_opf.sv
// Bench for dcpu16_opf: directed reset/PC-SP-write/stall-reset checks, a
// directed program with hand-computed results, and a random program checked
// against an instruction-level reference model through an expected queue.
module tb_dcpu16_opf;
   import dcpu16_pkg::*;

   localparam int W = 88;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ab_adr;
   logic        ab_stb;
   logic        ab_ack = 1'b0;
   logic [15:0] ab_dti = 16'h0000;
   logic [2:0]  rra;
   logic [15:0] rrd;
   logic [15:0] regO_i = 16'h0000;
   logic        skp;
   logic        pcw = 1'b0;
   logic [15:0] pcd = 16'h0000;
   logic        spw = 1'b0;
   logic [15:0] spd = 16'h0000;
   logic [3:0]  opc;
   logic [15:0] regA, regB, ea, pc, sp;
   logic        ena, nbi;
   logic [1:0]  amod;
   state_t      dbg_state;

   always #5 clk = ~clk;

   dcpu16_opf dut (
      .clk(clk), .rst(rst), .ab_adr(ab_adr), .ab_stb(ab_stb), .ab_ack(ab_ack),
      .ab_dti(ab_dti), .rra(rra), .rrd(rrd), .regO_i(regO_i), .skp(skp),
      .pcw(pcw), .pcd(pcd), .spw(spw), .spd(spd), .opc(opc), .regA(regA),
      .regB(regB), .ena(ena), .ea(ea), .amod(amod), .nbi(nbi), .pc(pc),
      .sp(sp), .dbg_state(dbg_state)
   );

   // Memory and register-file models
   logic [15:0] mem [0:65535];
   logic [15:0] regs [0:7];
   assign rrd = regs[rra];

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   logic [15:0]  adr_q[$];
   int           ena_cyc[$];
   int           n_chk = 0;
   int           n_pass = 0;
   int           cyc = 0;
   int           ins_idx = 0;
   int           run_len = 0;
   int           max_wait = 0;
   int           wait_left = 0;
   bit           bus_en = 1'b0;
   bit           skp_en = 1'b0;
   bit           skip_plan [0:255];

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction counter used only to steer skp for the instruction in EXE.
   always @(posedge clk) begin
      if (rst) ins_idx <= 0;
      else if (dbg_state == ST_EXE) ins_idx <= ins_idx + 1;
   end
   assign skp = skp_en && skip_plan[ins_idx[7:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [W-1:0] pk(input logic e, input logic n, input logic [3:0] o,
                                       input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] dea, input logic [1:0] am,
                                       input logic [15:0] p, input logic [15:0] s);
      return {e, n, o, a, b, (am == AMOD_LIT) ? 16'h0000 : dea, am, p, s};
   endfunction

   // Bus slave: random wait states, checks every acknowledged address.
   always @(negedge clk) begin
      if (bus_en) begin
         if (!rst && ab_stb && (ins_idx < run_len)) begin
            if (wait_left == 0) begin
               logic [15:0] ea_exp;
               ab_ack = 1'b1;
               ab_dti = mem[ab_adr];
               n_chk++;
               if (adr_q.size() == 0) begin
                  $display("FAIL bus_adr: got %h expected no read", ab_adr);
               end else begin
                  ea_exp = adr_q.pop_front();
                  if (ab_adr === ea_exp) n_pass++;
                  else $display("FAIL bus_adr: got %h expected %h", ab_adr, ea_exp);
               end
               wait_left = (max_wait == 0 || $urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, max_wait);
            end else begin
               ab_ack = 1'b0;
               wait_left--;
            end
         end else begin
            ab_ack = 1'b0;
         end
      end
   end

   // Monitor: every ena/nbi event is matched against the expected queue.
   always @(negedge clk) begin
      if (!rst && (ena || nbi)) begin
         logic [W-1:0] act, e;
         act = pk(ena, nbi, opc, regA, regB, ea, amod, pc, sp);
         ena_cyc.push_back(cyc);
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL exe_unexpected: got %h expected none", act);
         end else begin
            e = exp_q.pop_front();
            if (act === e) n_pass++;
            else $display("FAIL exe: got %h expected %h", act, e);
         end
      end
   end

   // Reference model: executes whole instructions from memory.
   logic [15:0] mpc, msp;

   task automatic resolve(input logic [5:0] f, output logic [15:0] v,
                          output logic [15:0] dea, output logic [1:0] am);
      logic [15:0] p;
      v = 16'h0; dea = 16'h0; am = AMOD_LIT; p = 16'h0;
      if (f >= 6'h20) begin
         v = 16'(f) - 16'h20;
      end else if (f < 6'h08) begin
         v = regs[f[2:0]]; dea = 16'(f); am = AMOD_REG;
      end else if (f == 6'h1b) begin
         v = msp; dea = 16'd0; am = AMOD_SPC;
      end else if (f == 6'h1c) begin
         v = mpc; dea = 16'd1; am = AMOD_SPC;
      end else if (f == 6'h1d) begin
         v = regO_i; dea = 16'd2; am = AMOD_SPC;
      end else if (f == 6'h1f) begin
         adr_q.push_back(mpc); v = mem[mpc]; mpc = mpc + 16'd1;
      end else begin
         if (f < 6'h10) p = regs[f[2:0]];
         else if (f < 6'h18) begin
            adr_q.push_back(mpc); p = mem[mpc] + regs[f[2:0]]; mpc = mpc + 16'd1;
         end else if (f == 6'h18) begin
            p = msp; msp = msp + 16'd1;
         end else if (f == 6'h19) p = msp;
         else if (f == 6'h1a) begin
            msp = msp - 16'd1; p = msp;
         end else begin
            adr_q.push_back(mpc); p = mem[mpc]; mpc = mpc + 16'd1;
         end
         adr_q.push_back(p); v = mem[p]; dea = p; am = AMOD_MEM;
      end
   endtask

   task automatic model_run(input int n);
      logic [15:0] w, va, vb, eaa, eab;
      logic [1:0]  ama, amb;
      mpc = 16'h0000; msp = 16'h0000;
      for (int i = 0; i < n; i++) begin
         adr_q.push_back(mpc);
         w = mem[mpc];
         mpc = mpc + 16'd1;
         resolve(w[9:4], va, eaa, ama);
         resolve(w[15:10], vb, eab, amb);
         if (!skip_plan[i])
            exp_q.push_back(pk(w[3:0] != 4'd0, w[3:0] == 4'd0, w[3:0], va, vb, eaa, ama, mpc, msp));
      end
   endtask

   task automatic run_until(input int n, input int budget, input string name);
      for (int c = 0; c < budget && ins_idx < n; c++) @(posedge clk);
      @(negedge clk);
      check(name, ins_idx, n);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = {16'($urandom) & 16'hFFF0} | 16'($urandom_range(1, 15));
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      for (int i = 0; i < 256; i++) skip_plan[i] = 1'b0;
      regs[0] = 16'h0005;
      regs[6] = 16'h0004;

      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stb", ab_stb, 0);
      check("rst_ena", ena, 0);
      check("rst_nbi", nbi, 0);
      check("rst_pc", pc, 16'h0000);
      check("rst_sp", sp, 16'h0000);
      check("rst_opc", opc, 0);
      check("rst_rega", regA, 0);
      check("rst_regb", regB, 0);
      check("rst_ea", ea, 0);
      check("rst_amod", amod, 0);
      check("rst_rra", rra, 0);
      check("rst_state", dbg_state, ST_FETCH);

      // PC/SP writeback while FETCH waits on the bus
      rst = 1'b0;
      @(negedge clk);
      check("fetch_stb", ab_stb, 1);
      check("fetch_adr", ab_adr, 16'h0000);
      pcw = 1'b1; pcd = 16'h0100; spw = 1'b1; spd = 16'h0200;
      @(negedge clk);
      pcw = 1'b0; spw = 1'b0;
      check("pcw_pc", pc, 16'h0100);
      check("spw_sp", sp, 16'h0200);
      check("pcw_adr", ab_adr, 16'h0100);

      // Stall during NWA, then reset in the middle of LDA
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ab_ack = 1'b1; ab_dti = 16'h8161;
      @(negedge clk);
      ab_ack = 1'b0;
      check("stall_opa", dbg_state, ST_OPA);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_state", dbg_state, ST_NWA);
         check("stall_adr", ab_adr, 16'h0001);
      end
      ab_ack = 1'b1; ab_dti = 16'h1000;
      @(negedge clk);
      ab_ack = 1'b0;
      check("lda_state", dbg_state, ST_LDA);
      check("lda_adr", ab_adr, 16'h1004);
      check("lda_pc", pc, 16'h0002);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_stb", ab_stb, 0);
      check("midrst_ena", ena, 0);
      check("midrst_pc", pc, 16'h0000);
      check("midrst_sp", sp, 16'h0000);
      check("midrst_state", dbg_state, ST_FETCH);
      rst = 1'b0;
      @(negedge clk);
      check("refetch_stb", ab_stb, 1);
      check("refetch_adr", ab_adr, 16'h0000);
      rst = 1'b1;

      // Directed program with hand-computed results, zero-wait bus
      mem[0] = 16'h7C01; mem[1] = 16'h0030;   // SET A, 0x30
      mem[2] = 16'hC002;                      // ADD A, 0x10
      mem[3] = 16'h8161; mem[4] = 16'h1000;   // SET [0x1000+I], 0
      mem[5] = 16'h01A1;                      // SET PUSH, A
      mem[6] = 16'h6001;                      // SET A, POP
      mem[7] = 16'h7C01; mem[8] = 16'h0030;   // skipped
      mem[9] = 16'h7C01; mem[10] = 16'h0030;  // SET A, 0x30
      mem[11] = 16'h0000;                     // non-basic
      mem[16'h1004] = 16'hBEEF;
      mem[16'hFFFF] = 16'h1234;
      skip_plan[5] = 1'b1;
      exp_q.push_back(pk(1, 0, 4'd1, 16'h0005, 16'h0030, 16'h0000, 2'd0, 16'd2, 16'h0000));
      exp_q.push_back(pk(1, 0, 4'd2, 16'h0005, 16'h0010, 16'h0000, 2'd0, 16'd3, 16'h0000));
      exp_q.push_back(pk(1, 0, 4'd1, 16'hBEEF, 16'h0000, 16'h1004, 2'd1, 16'd5, 16'h0000));
      exp_q.push_back(pk(1, 0, 4'd1, 16'h1234, 16'h0005, 16'hFFFF, 2'd1, 16'd6, 16'hFFFF));
      exp_q.push_back(pk(1, 0, 4'd1, 16'h0005, 16'h1234, 16'h0000, 2'd0, 16'd7, 16'h0000));
      exp_q.push_back(pk(1, 0, 4'd1, 16'h0005, 16'h0030, 16'h0000, 2'd0, 16'd11, 16'h0000));
      exp_q.push_back(pk(0, 1, 4'd0, 16'h0005, 16'h0005, 16'h0000, 2'd0, 16'd12, 16'h0000));
      adr_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'h1004, 16'd5, 16'hFFFF,
                16'd6, 16'hFFFF, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11};
      ena_cyc.delete();
      max_wait = 0; wait_left = 0; run_len = 8; skp_en = 1'b1; bus_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_until(8, 400, "dir_done");
      check("dir_exp_left", exp_q.size(), 0);
      check("dir_adr_left", adr_q.size(), 0);
      if (ena_cyc.size() >= 2) check("min_latency", ena_cyc[1] - ena_cyc[0], 4);
      else check("min_latency_events", ena_cyc.size(), 2);

      // Random program against the reference model, random wait states
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 65536; i++) mem[i] = {16'($urandom) & 16'hFFF0} | 16'($urandom_range(1, 15));
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      for (int i = 0; i < 256; i++) skip_plan[i] = ($urandom_range(0, 4) == 0);
      regO_i = 16'($urandom);
      exp_q.delete(); adr_q.delete();
      model_run(80);
      max_wait = 2; wait_left = 0; run_len = 80;
      @(negedge clk);
      rst = 1'b0;
      run_until(80, 20000, "rand_done");
      check("rand_exp_left", exp_q.size(), 0);
      check("rand_adr_left", adr_q.size(), 0);

      rst = 1'b1;
      bus_en = 1'b0;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
